twice_hls_deadlock_detector: RTL and testbench

TWICE_HLS_DEADLOCK_DETECTOR -- requirements
Module: twice_hls_deadlock_detector

---
 rtl/twice_hls_deadlock_pkg.sv | 22 ++
 rtl/twice_hls_deadlock_sat_cnt.sv | 38 +++
 rtl/twice_hls_deadlock_detector.sv | 165 ++++++++++++++++
 tb/tb_twice_hls_deadlock_detector.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/twice_hls_deadlock_pkg.sv
// ----------------------------------------------------------------------------
// twice_hls_deadlock_pkg
// Shared definitions for the HLS deadlock detector:
//   - state_t        : detector FSM state encoding
//   - DEFAULT_*      : default THRESHOLD / CNT_W parameter values
//   - PORTS_W        : number of AXIS port block flags
//   - TIMESTAMP_W    : width of the detection timestamp / cycle counter
// ----------------------------------------------------------------------------
package twice_hls_deadlock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SUSPECT  = 2'd1,
        ST_DEADLOCK = 2'd2
    } state_t;

    localparam int DEFAULT_THRESHOLD = 1024;
    localparam int DEFAULT_CNT_W     = 16;
    localparam int PORTS_W           = 2;
    localparam int TIMESTAMP_W       = 64;

endpackage : twice_hls_deadlock_pkg

// File: rtl/twice_hls_deadlock_sat_cnt.sv
// ----------------------------------------------------------------------------
// twice_hls_deadlock_sat_cnt
// CNT_W-bit saturating up-counter with synchronous clear.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset (count -> 0)
//   clr   : synchronous clear, has priority over inc
//   inc   : increment by one, sticks at all-ones
//   count : registered counter value
// When neither clr nor inc is asserted the count holds.
// ----------------------------------------------------------------------------
module twice_hls_deadlock_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != CNT_MAX)) begin
            count_reg <= count_reg + CNT_ONE;
        end
    end

    assign count = count_reg;

endmodule : twice_hls_deadlock_sat_cnt

// File: rtl/twice_hls_deadlock_detector.sv
// ----------------------------------------------------------------------------
// twice_hls_deadlock_detector
// Watches the registered block flag of the twice_twice_inst deadlock monitor
// and declares a sticky deadlock after THRESHOLD consecutive blocked cycles.
//
// Parameters:
//   THRESHOLD : consecutive block=1 samples that declare deadlock (1..2**CNT_W-1)
//   CNT_W     : width of the saturating stall counter
// Ports:
//   clock           : sole clock, rising edge
//   reset           : asynchronous active-high reset
//   block           : monitor block flag
//   axis_block_sigs : per-AXIS-port block flags
//   clear           : one-cycle pulse releasing a latched deadlock / restarting
//   deadlock        : sticky deadlock indication
//   deadlock_ports  : OR of axis_block_sigs over the detecting window
//   stall_count     : consecutive-block count, saturating
//   timestamp       : cycle number of detection
//                     (only when TWICE_DEADLOCK_TIMESTAMP_EN is defined)
// All outputs come straight from registers.
// ----------------------------------------------------------------------------
module twice_hls_deadlock_detector
    import twice_hls_deadlock_pkg::*;
#(
    parameter int THRESHOLD = DEFAULT_THRESHOLD,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   block,
    input  logic [PORTS_W-1:0]     axis_block_sigs,
    input  logic                   clear,
    output logic                   deadlock,
    output logic [PORTS_W-1:0]     deadlock_ports,
    output logic [CNT_W-1:0]       stall_count
`ifdef TWICE_DEADLOCK_TIMESTAMP_EN
    ,
    output logic [TIMESTAMP_W-1:0] timestamp
`endif
);

    // Threshold compared against the incremented count; one extra bit so the
    // increment of a saturated counter never wraps into a false match.
    localparam logic [CNT_W:0] THRESH_EXT = (CNT_W+1)'(THRESHOLD);
    localparam bit             THRESH_ONE = (THRESHOLD == 1);

    state_t             state_reg, state_next;
    logic [PORTS_W-1:0] acc_reg, acc_next;
    logic [PORTS_W-1:0] ports_reg, ports_next;
    logic               cnt_clr, cnt_inc;
    logic [CNT_W:0]     count_plus;
    logic [PORTS_W-1:0] acc_with_cur;

    twice_hls_deadlock_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_sat_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (stall_count)
    );

    assign count_plus   = {1'b0, stall_count} + {{CNT_W{1'b0}}, 1'b1};
    assign acc_with_cur = acc_reg | axis_block_sigs;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            ports_reg <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            ports_reg <= ports_next;
        end
    end

    // Next-state logic. clear is checked first in every state so that it
    // beats a detecting edge in the same cycle.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        ports_next = ports_reg;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (clear || !block) begin
                    cnt_clr  = 1'b1;
                    acc_next = '0;
                end else begin
                    cnt_inc  = 1'b1;
                    acc_next = acc_with_cur;
                    if (THRESH_ONE) begin
                        state_next = ST_DEADLOCK;
                        ports_next = acc_with_cur;
                    end else begin
                        state_next = ST_SUSPECT;
                    end
                end
            end
            ST_SUSPECT: begin
                if (clear || !block) begin
                    state_next = ST_IDLE;
                    cnt_clr    = 1'b1;
                    acc_next   = '0;
                end else begin
                    cnt_inc  = 1'b1;
                    acc_next = acc_with_cur;
                    if (count_plus == THRESH_EXT) begin
                        state_next = ST_DEADLOCK;
                        ports_next = acc_with_cur;
                    end
                end
            end
            ST_DEADLOCK: begin
                if (clear) begin
                    state_next = ST_IDLE;
                    cnt_clr    = 1'b1;
                    acc_next   = '0;
                    ports_next = '0;
                end else begin
                    // Sticky: the counter keeps tracking the stall length.
                    cnt_inc = block;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_clr    = 1'b1;
                acc_next   = '0;
                ports_next = '0;
            end
        endcase
    end

    assign deadlock       = (state_reg == ST_DEADLOCK);
    assign deadlock_ports = ports_reg;

`ifdef TWICE_DEADLOCK_TIMESTAMP_EN
    // Free-running cycle counter: holds N while the N-th rising edge after
    // reset release (counting from 0) is being taken.
    logic [TIMESTAMP_W-1:0] cycle_reg;
    logic [TIMESTAMP_W-1:0] ts_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_reg <= '0;
            ts_reg    <= '0;
        end else begin
            cycle_reg <= cycle_reg + {{(TIMESTAMP_W-1){1'b0}}, 1'b1};
            if ((state_reg != ST_DEADLOCK) && (state_next == ST_DEADLOCK)) begin
                ts_reg <= cycle_reg;
            end else if ((state_reg == ST_DEADLOCK) && (state_next != ST_DEADLOCK)) begin
                ts_reg <= '0;
            end
        end
    end

    assign timestamp = ts_reg;
`else
    // Without the timestamp option there is no cycle counter at all.
`endif

endmodule : twice_hls_deadlock_detector

// File: tb/tb_twice_hls_deadlock_detector.sv
// ----------------------------------------------------------------------------
// tb_twice_hls_deadlock_detector
// Directed bench for twice_hls_deadlock_detector. Four instances share the
// stimulus: THRESHOLD=4 (main), CNT_W=3/THRESHOLD=2 (saturation),
// THRESHOLD=1 (direct detection) and THRESHOLD=5 (timestamp, only checked
// when TWICE_DEADLOCK_TIMESTAMP_EN is defined).
// ----------------------------------------------------------------------------
module tb_twice_hls_deadlock_detector;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       block = 1'b0;
    logic [1:0] axis_block_sigs = 2'b00;
    logic       clear = 1'b0;

    logic        t4_deadlock,  sat_deadlock,  t1_deadlock,  t5_deadlock;
    logic [1:0]  t4_ports,     sat_ports,     t1_ports,     t5_ports;
    logic [15:0] t4_count,     t1_count,      t5_count;
    logic [2:0]  sat_count;
`ifdef TWICE_DEADLOCK_TIMESTAMP_EN
    logic [63:0] t4_ts, sat_ts, t1_ts, t5_ts;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    twice_hls_deadlock_detector #(.THRESHOLD(4), .CNT_W(16)) u_t4 (
        .clock(clock), .reset(reset), .block(block),
        .axis_block_sigs(axis_block_sigs), .clear(clear),
        .deadlock(t4_deadlock), .deadlock_ports(t4_ports), .stall_count(t4_count)
`ifdef TWICE_DEADLOCK_TIMESTAMP_EN
        , .timestamp(t4_ts)
`endif
    );

    twice_hls_deadlock_detector #(.THRESHOLD(2), .CNT_W(3)) u_sat (
        .clock(clock), .reset(reset), .block(block),
        .axis_block_sigs(axis_block_sigs), .clear(clear),
        .deadlock(sat_deadlock), .deadlock_ports(sat_ports), .stall_count(sat_count)
`ifdef TWICE_DEADLOCK_TIMESTAMP_EN
        , .timestamp(sat_ts)
`endif
    );

    twice_hls_deadlock_detector #(.THRESHOLD(1), .CNT_W(16)) u_t1 (
        .clock(clock), .reset(reset), .block(block),
        .axis_block_sigs(axis_block_sigs), .clear(clear),
        .deadlock(t1_deadlock), .deadlock_ports(t1_ports), .stall_count(t1_count)
`ifdef TWICE_DEADLOCK_TIMESTAMP_EN
        , .timestamp(t1_ts)
`endif
    );

    twice_hls_deadlock_detector #(.THRESHOLD(5), .CNT_W(16)) u_t5 (
        .clock(clock), .reset(reset), .block(block),
        .axis_block_sigs(axis_block_sigs), .clear(clear),
        .deadlock(t5_deadlock), .deadlock_ports(t5_ports), .stall_count(t5_count)
`ifdef TWICE_DEADLOCK_TIMESTAMP_EN
        , .timestamp(t5_ts)
`endif
    );

    // Inputs change 1 time unit after a rising edge; outputs are sampled there.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        block = 1'b0;
        clear = 1'b0;
        axis_block_sigs = 2'b00;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        block = 1'b1;
        tick();
        tick();
        do_reset();
        tests_run++; if (t4_deadlock !== 1'b0) begin tests_failed++; $display("FAIL reset_deadlock: got %0b want 0", t4_deadlock); end
        tests_run++; if (t4_count !== 16'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", t4_count); end
        tests_run++; if (t4_ports !== 2'b00) begin tests_failed++; $display("FAIL reset_ports: got %b want 00", t4_ports); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_detect();
        do_reset();
        block = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            tests_run++; if (t4_count !== 16'(i)) begin tests_failed++; $display("FAIL detect_count[%0d]: got %0d want %0d", i, t4_count, i); end
            tests_run++; if (t4_deadlock !== (i == 4)) begin tests_failed++; $display("FAIL detect_deadlock[%0d]: got %0b want %0b", i, t4_deadlock, (i == 4)); end
        end
        // Three blocked samples then a release must not detect.
        do_reset();
        block = 1'b1;
        repeat (3) tick();
        tests_run++; if (t4_count !== 16'd3) begin tests_failed++; $display("FAIL short_count3: got %0d want 3", t4_count); end
        block = 1'b0;
        tick();
        tests_run++; if (t4_count !== 16'd0) begin tests_failed++; $display("FAIL short_count0: got %0d want 0", t4_count); end
        repeat (3) tick();
        tests_run++; if (t4_deadlock !== 1'b0) begin tests_failed++; $display("FAIL short_deadlock: got %0b want 0", t4_deadlock); end
        $display("[TB] test_detect done");
    endtask

    task automatic test_ports();
        do_reset();
        block = 1'b1;
        axis_block_sigs = 2'b01;
        repeat (2) tick();
        axis_block_sigs = 2'b10;
        tick();
        tests_run++; if (t4_ports !== 2'b00) begin tests_failed++; $display("FAIL ports_pre: got %b want 00", t4_ports); end
        tick();
        tests_run++; if (t4_ports !== 2'b11) begin tests_failed++; $display("FAIL ports_detect: got %b want 11", t4_ports); end
        axis_block_sigs = 2'b00;
        tick();
        tests_run++; if (t4_ports !== 2'b11) begin tests_failed++; $display("FAIL ports_hold00: got %b want 11", t4_ports); end
        axis_block_sigs = 2'b01;
        tick();
        tests_run++; if (t4_ports !== 2'b11) begin tests_failed++; $display("FAIL ports_hold01: got %b want 11", t4_ports); end
        // A gap in block discards what was accumulated before it.
        do_reset();
        block = 1'b1;
        axis_block_sigs = 2'b01;
        repeat (2) tick();
        block = 1'b0;
        tick();
        block = 1'b1;
        axis_block_sigs = 2'b10;
        repeat (4) tick();
        tests_run++; if (t4_deadlock !== 1'b1) begin tests_failed++; $display("FAIL gap_deadlock: got %0b want 1", t4_deadlock); end
        tests_run++; if (t4_ports !== 2'b10) begin tests_failed++; $display("FAIL gap_ports: got %b want 10", t4_ports); end
        $display("[TB] test_ports done");
    endtask

    task automatic test_saturate();
        do_reset();
        block = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            tests_run++; if (sat_count !== 3'((i > 7) ? 7 : i)) begin tests_failed++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, sat_count, (i > 7) ? 7 : i); end
            tests_run++; if (sat_deadlock !== (i >= 2)) begin tests_failed++; $display("FAIL sat_deadlock[%0d]: got %0b want %0b", i, sat_deadlock, (i >= 2)); end
        end
        block = 1'b0;
        tick();
        tests_run++; if (sat_count !== 3'd7) begin tests_failed++; $display("FAIL sat_hold_count: got %0d want 7", sat_count); end
        tests_run++; if (sat_deadlock !== 1'b1) begin tests_failed++; $display("FAIL sat_sticky: got %0b want 1", sat_deadlock); end
        $display("[TB] test_saturate done");
    endtask

    task automatic test_clear();
        do_reset();
        block = 1'b1;
        axis_block_sigs = 2'b01;
        repeat (6) tick();
        tests_run++; if (t4_count !== 16'd6) begin tests_failed++; $display("FAIL clr_pre_count: got %0d want 6", t4_count); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tests_run++; if (t4_deadlock !== 1'b0) begin tests_failed++; $display("FAIL clr_deadlock: got %0b want 0", t4_deadlock); end
        tests_run++; if (t4_count !== 16'd0) begin tests_failed++; $display("FAIL clr_count: got %0d want 0", t4_count); end
        tests_run++; if (t4_ports !== 2'b00) begin tests_failed++; $display("FAIL clr_ports: got %b want 00", t4_ports); end
        repeat (3) tick();
        tests_run++; if (t4_deadlock !== 1'b0) begin tests_failed++; $display("FAIL rearm_early: got %0b want 0", t4_deadlock); end
        tick();
        tests_run++; if (t4_deadlock !== 1'b1) begin tests_failed++; $display("FAIL rearm_detect: got %0b want 1", t4_deadlock); end
        // clear coincident with what would be the detecting edge.
        do_reset();
        block = 1'b1;
        repeat (3) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tests_run++; if (t4_deadlock !== 1'b0) begin tests_failed++; $display("FAIL clr_coinc_deadlock: got %0b want 0", t4_deadlock); end
        tests_run++; if (t4_count !== 16'd0) begin tests_failed++; $display("FAIL clr_coinc_count: got %0d want 0", t4_count); end
        repeat (3) tick();
        tests_run++; if (t4_deadlock !== 1'b0) begin tests_failed++; $display("FAIL clr_coinc_window: got %0b want 0", t4_deadlock); end
        tick();
        tests_run++; if (t4_deadlock !== 1'b1) begin tests_failed++; $display("FAIL clr_coinc_redetect: got %0b want 1", t4_deadlock); end
        $display("[TB] test_clear done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        block = 1'b1;
        axis_block_sigs = 2'b11;
        repeat (3) tick();
        tests_run++; if (t4_count !== 16'd3) begin tests_failed++; $display("FAIL mid_pre_count: got %0d want 3", t4_count); end
        reset = 1'b1;
        #1;
        tests_run++; if (t4_count !== 16'd0) begin tests_failed++; $display("FAIL mid_async_count: got %0d want 0", t4_count); end
        tests_run++; if (t4_deadlock !== 1'b0) begin tests_failed++; $display("FAIL mid_async_deadlock: got %0b want 0", t4_deadlock); end
        tick();
        reset = 1'b0;
        repeat (3) tick();
        tests_run++; if (t4_deadlock !== 1'b0) begin tests_failed++; $display("FAIL mid_window_early: got %0b want 0", t4_deadlock); end
        tick();
        tests_run++; if (t4_deadlock !== 1'b1) begin tests_failed++; $display("FAIL mid_window_detect: got %0b want 1", t4_deadlock); end
        tests_run++; if (t4_count !== 16'd4) begin tests_failed++; $display("FAIL mid_window_count: got %0d want 4", t4_count); end
        $display("[TB] test_reset_mid done");
    endtask

    task automatic test_threshold_one();
        do_reset();
        block = 1'b1;
        axis_block_sigs = 2'b10;
        tick();
        tests_run++; if (t1_deadlock !== 1'b1) begin tests_failed++; $display("FAIL t1_deadlock: got %0b want 1", t1_deadlock); end
        tests_run++; if (t1_count !== 16'd1) begin tests_failed++; $display("FAIL t1_count: got %0d want 1", t1_count); end
        tests_run++; if (t1_ports !== 2'b10) begin tests_failed++; $display("FAIL t1_ports: got %b want 10", t1_ports); end
        block = 1'b0;
        repeat (2) tick();
        tests_run++; if (t1_deadlock !== 1'b1) begin tests_failed++; $display("FAIL t1_sticky: got %0b want 1", t1_deadlock); end
        tests_run++; if (t1_count !== 16'd1) begin tests_failed++; $display("FAIL t1_hold: got %0d want 1", t1_count); end
        $display("[TB] test_threshold_one done");
    endtask

`ifdef TWICE_DEADLOCK_TIMESTAMP_EN
    task automatic test_timestamp();
        do_reset();
        repeat (10) tick();
        block = 1'b1;
        repeat (4) tick();
        tests_run++; if (t5_deadlock !== 1'b0) begin tests_failed++; $display("FAIL ts_early: got %0b want 0", t5_deadlock); end
        tick();
        tests_run++; if (t5_deadlock !== 1'b1) begin tests_failed++; $display("FAIL ts_deadlock: got %0b want 1", t5_deadlock); end
        tests_run++; if (t5_ts !== 64'd14) begin tests_failed++; $display("FAIL ts_value: got %0d want 14", t5_ts); end
        repeat (3) tick();
        tests_run++; if (t5_ts !== 64'd14) begin tests_failed++; $display("FAIL ts_hold: got %0d want 14", t5_ts); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tests_run++; if (t5_ts !== 64'd0) begin tests_failed++; $display("FAIL ts_clear: got %0d want 0", t5_ts); end
        $display("[TB] test_timestamp done");
    endtask
`endif

    initial begin
        test_reset();
        test_detect();
        test_ports();
        test_saturate();
        test_clear();
        test_reset_mid();
        test_threshold_one();
`ifdef TWICE_DEADLOCK_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_twice_hls_deadlock_detector
